// File: rtl/half_duplex_line_ctrl.sv
// rtl/half_duplex_line_ctrl.sv - tri-state line sequencer: shift command out, turn around, sample response
module half_duplex_line_ctrl #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int TURN_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_word,
    input  logic             line_in,
    output logic             buf_a,
    output logic             buf_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_word
);
    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_SAMPLE = BCW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(WIDTH - 1);
    localparam logic [TW-1:0]  TURN_LAST  = TW'(TURN_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_TURN  = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_word_q, rx_word_d;
    logic             buf_a_q, buf_en_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        turn_d    = turn_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_word_d = rx_word_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_sh_d   = tx_word;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    tx_sh_d   = tx_sh_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        turn_d  = '0;
                        state_d = S_TURN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            S_TURN: begin
                if (turn_q == TURN_LAST) begin
                    turn_d    = '0;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = S_RECV;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            S_RECV: begin
                // Mid-bit sample; new bits enter at the MSB so the first bit ends up at [0].
                if (bit_cnt_q == BIT_SAMPLE) begin
                    rx_sh_d = (rx_sh_q >> 1) | (WIDTH'(line_in) << (WIDTH - 1));
                end
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        rx_word_d = rx_sh_d;
                        state_d   = S_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            turn_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_word_q <= '0;
            buf_a_q   <= 1'b0;
            buf_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            turn_q    <= turn_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_word_q <= rx_word_d;
            // Pad controls are registered from next state so they line up with the state cycle.
            buf_en_q  <= (state_d == S_DRIVE);
            buf_a_q   <= (state_d == S_DRIVE) && tx_sh_d[0];
        end
    end

    assign buf_a   = buf_a_q;
    assign buf_en  = buf_en_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign rx_word = rx_word_q;
endmodule
